instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
- Instruction fetch stage sitting directly downstream of the program counter.
- Owns the fetch address and issues byte reads to program memory.
- Assembles two-byte instructions and buffers them in a small FIFO for the decoder.
- Flushes the FIFO and restarts fetch on a branch/jump redirect, which is the same LOAD/ADDRESS event the PC consumes.

Parameters:
- DEPTH, 4, instruction queue entries (power of two, ≥2).
- RESET_ADDR, 16'h0000, fetch address after reset; LSB must be 0.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- BRANCH  input  1  redirect strobe; same event as the PC's LOAD.
- BRANCH_ADDR  input  16  redirect target; bit 0 ignored (forced 0).
- MEM_ADDR  output  16  byte address of the current read.
- MEM_RD  output  1  one-cycle read request pulse.
- MEM_RDATA  input  8  read data.
- MEM_VALID  input  1  MEM_RDATA valid; earliest one cycle after MEM_RD, latency unbounded.
- INSTR  output  16  head instruction, {byte@A, byte@A+1}.
- INSTR_PC  output  16  address A of the head instruction.
- INSTR_VALID  output  1  queue non-empty.
- INSTR_READY  input  1  decoder pops the head when INSTR_VALID && INSTR_READY.
- QUEUE_COUNT  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async):
  - fetch_addr=RESET_ADDR; queue empty.
  - MEM_RD=0, MEM_ADDR=RESET_ADDR.
  - INSTR_VALID=0, INSTR=0, INSTR_PC=0, QUEUE_COUNT=0.
  - drop=0; state IDLE.
- FSM states: IDLE, REQ_HI, WAIT_HI, REQ_LO, WAIT_LO.
- IDLE → REQ_HI when a slot is free: QUEUE_COUNT < DEPTH after accounting for a pop this cycle. Otherwise hold in IDLE.
- REQ_HI: MEM_RD=1, MEM_ADDR=fetch_addr for exactly one cycle → WAIT_HI.
- WAIT_HI: on MEM_VALID, latch hi byte → REQ_LO.
- REQ_LO: MEM_RD=1, MEM_ADDR=fetch_addr+1 for one cycle → WAIT_LO.
- WAIT_LO, on MEM_VALID:
  - push {hi, MEM_RDATA} with PC=fetch_addr;
  - fetch_addr += 2, 16-bit wrap (16'hFFFE → 16'h0000);
  - → IDLE.
- Pushed entry is visible on INSTR/INSTR_VALID the cycle after the MEM_VALID edge.
- Best-case throughput: one instruction per 5 cycles, including the IDLE cycle.
- Queue: registered circular FIFO.
  - Simultaneous push and pop when full: the free-slot check prevents overflow, so no push occurs while full.
  - Simultaneous push and pop when non-full: both occur, count unchanged.
  - Pop when empty is ignored.
- BRANCH (highest priority):
  - Next edge: queue emptied, QUEUE_COUNT=0, INSTR_VALID=0, fetch_addr={BRANCH_ADDR[15:1],0}, state → IDLE.
  - Any concurrent pop or push is discarded.
  - If a read is outstanding (branch in WAIT_* with MEM_VALID low, or in REQ_*): set drop=1. The next MEM_VALID is swallowed and clears drop. No new MEM_RD is issued while drop=1.
  - If MEM_VALID coincides with BRANCH, that response is discarded and drop stays 0.
  - A BRANCH while drop=1 keeps drop=1.
- Only one memory request is ever outstanding.
- MEM_ADDR holds its last value outside REQ states.

Test Plan:
- Reset, then memory with 1-cycle latency, bytes 00:12,01:34,02:56,03:78, INSTR_READY=1 → INSTR=16'h1234 with INSTR_PC=0, then INSTR=16'h5678 with INSTR_PC=2; MEM_RD pulses at addresses 0,1,2,3.
- INSTR_READY=0, DEPTH=4 → after 4 pushes QUEUE_COUNT=4 and no further MEM_RD. Raise READY for 1 cycle → count 3, exactly one new 2-byte fetch, count back to 4.
- BRANCH with BRANCH_ADDR=16'h0101 while in WAIT_LO with 3-cycle latency → queue empties next cycle. The late MEM_VALID is dropped (no push). The next MEM_RD has address 16'h0100.
- BRANCH asserted on the same cycle as a pop and a push → QUEUE_COUNT=0, INSTR_VALID=0 the next cycle, no stale entry appears later.
- Fetch from 16'hFFFE → instruction pushed with INSTR_PC=16'hFFFE, next MEM_ADDR=16'h0000.
- Assert RST mid-WAIT_HI → outputs return to reset values immediately; after release, the first MEM_RD has address RESET_ADDR and the stale response is ignored because RST cleared state.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: byte-wise reads from program memory, two-byte
// instruction assembly, a circular instruction queue for the decoder, and
// flush/restart on branch with dropping of an in-flight memory response.
module instr_fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      BRANCH,
    input  logic [15:0]               BRANCH_ADDR,
    output logic [15:0]               MEM_ADDR,
    output logic                      MEM_RD,
    input  logic [7:0]                MEM_RDATA,
    input  logic                      MEM_VALID,
    output logic [15:0]               INSTR,
    output logic [15:0]               INSTR_PC,
    output logic                      INSTR_VALID,
    input  logic                      INSTR_READY,
    output logic [$clog2(DEPTH):0]    QUEUE_COUNT
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_HI  = 3'd1,
        WAIT_HI = 3'd2,
        REQ_LO  = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   fetch_addr;
    logic [15:0]   fetch_addr_next;
    logic [7:0]    hi_byte;
    logic          drop;
    logic          drop_next;
    logic          push;
    logic          pop;
    logic          latch_hi;
    logic          mem_rd_next;
    logic [15:0]   mem_addr_next;
    logic [15:0]   instr_q [DEPTH];
    logic [15:0]   pc_q    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign INSTR_VALID = (QUEUE_COUNT != '0);
    assign INSTR       = instr_q[rd_ptr];
    assign INSTR_PC    = pc_q[rd_ptr];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, fetch address, drop flag, queue strobes and memory request
    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        drop_next       = drop;
        push            = 1'b0;
        pop             = 1'b0;
        latch_hi        = 1'b0;
        mem_rd_next     = 1'b0;
        mem_addr_next   = MEM_ADDR;

        if (BRANCH) begin
            // Redirect wins; remember whether a response is still in flight
            state_next      = IDLE;
            fetch_addr_next = BRANCH_ADDR & 16'hFFFE;
            drop_next       = (state == REQ_HI) || (state == REQ_LO)
                           || (((state == WAIT_HI) || (state == WAIT_LO)) && !MEM_VALID)
                           || (drop && !MEM_VALID);
        end else begin
            pop = INSTR_VALID && INSTR_READY;
            if (drop && MEM_VALID) begin
                drop_next = 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!drop && ((QUEUE_COUNT < CW'(DEPTH)) || pop)) begin
                        state_next = REQ_HI;
                    end
                end
                REQ_HI:  state_next = WAIT_HI;
                WAIT_HI: begin
                    if (MEM_VALID) begin
                        latch_hi   = 1'b1;
                        state_next = REQ_LO;
                    end
                end
                REQ_LO:  state_next = WAIT_LO;
                WAIT_LO: begin
                    if (MEM_VALID) begin
                        push            = 1'b1;
                        fetch_addr_next = fetch_addr + 16'd2;
                        state_next      = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Memory request is issued in the cycle the FSM sits in a REQ state
        if (state_next == REQ_HI) begin
            mem_rd_next   = 1'b1;
            mem_addr_next = fetch_addr;
        end else if (state_next == REQ_LO) begin
            mem_rd_next   = 1'b1;
            mem_addr_next = fetch_addr | 16'h0001;
        end
    end

    // Fetch address, drop flag, hi byte and memory interface registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_addr <= RESET_ADDR;
            drop       <= 1'b0;
            hi_byte    <= 8'h00;
            MEM_RD     <= 1'b0;
            MEM_ADDR   <= RESET_ADDR;
        end else begin
            fetch_addr <= fetch_addr_next;
            drop       <= drop_next;
            MEM_RD     <= mem_rd_next;
            MEM_ADDR   <= mem_addr_next;
            if (latch_hi) begin
                hi_byte <= MEM_RDATA;
            end
        end
    end

    // Circular instruction queue; a branch flushes it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            QUEUE_COUNT <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 16'h0000;
                pc_q[i]    <= 16'h0000;
            end
        end else if (BRANCH) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            QUEUE_COUNT <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= {hi_byte, MEM_RDATA};
                pc_q[wr_ptr]    <= fetch_addr;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   QUEUE_COUNT <= QUEUE_COUNT + CW'(1);
                2'b01:   QUEUE_COUNT <= QUEUE_COUNT - CW'(1);
                default: QUEUE_COUNT <= QUEUE_COUNT;
            endcase
        end
    end

endmodule
